// File: rtl/k423_if_pkg.sv
// k423_if_pkg: shared types and fetch-group geometry helpers for the IF-stage
// PC generator.
//   redir_src_t   - which source drives the next PC
//   pcgen_state_t - PC generator FSM state
//   off_w()       - lane-offset width for a given fetch width (0 when FETCH_W=1)
//   lane_w()      - lane-index port width (never below 1)
//   grp_bytes()   - bytes covered by one fetch group
package k423_if_pkg;

    typedef enum logic [1:0] {
        REDIR_NONE = 2'd0,
        REDIR_EXCP = 2'd1,
        REDIR_BJU  = 2'd2,
        REDIR_BPU  = 2'd3
    } redir_src_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } pcgen_state_t;

    function automatic int unsigned off_w(input int unsigned fw);
        return (fw <= 1) ? 0 : $clog2(fw);
    endfunction

    function automatic int unsigned lane_w(input int unsigned fw);
        return (off_w(fw) == 0) ? 1 : off_w(fw);
    endfunction

    function automatic int unsigned grp_bytes(input int unsigned fw);
        return fw * 4;
    endfunction

    localparam int unsigned DEF_FETCH_W   = 2;
    localparam int unsigned DEF_OFF_W     = off_w(DEF_FETCH_W);
    localparam int unsigned DEF_GRP_BYTES = grp_bytes(DEF_FETCH_W);

endpackage

// File: rtl/k423_if_lane_mask.sv
// k423_if_lane_mask: combinational valid-lane mask for one fetch group.
//   off      : lane of the group start PC (lanes below it are not fetched)
//   bpu_tkn  : a predicted-taken branch sits in this group
//   bpu_lane : lane holding that branch (lanes after it are squashed)
//   mask     : one bit per lane, 1 = instruction valid
module k423_if_lane_mask
    import k423_if_pkg::*;
#(
    parameter int unsigned FETCH_W = 2
) (
    input  logic [lane_w(FETCH_W)-1:0] off,
    input  logic                       bpu_tkn,
    input  logic [lane_w(FETCH_W)-1:0] bpu_lane,
    output logic [FETCH_W-1:0]         mask
);

    localparam int unsigned LW = lane_w(FETCH_W);

    logic [31:0] off_ext;
    logic [31:0] lane_ext;

    always_comb begin
        off_ext  = {{(32-LW){1'b0}}, off};
        lane_ext = {{(32-LW){1'b0}}, bpu_lane};
        mask     = '0;
        for (int unsigned i = 0; i < FETCH_W; i++) begin
            mask[i] = (i >= off_ext) && (!bpu_tkn || (i <= lane_ext));
        end
    end

endmodule

// File: rtl/utils_adder32.sv
// utils_adder32: plain 32-bit adder with carry-in.
//   a, b : operands
//   ci   : carry in
//   sum  : a + b + ci modulo 2^32
module utils_adder32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        ci,
    output logic [31:0] sum
);

    always_comb begin
        sum = a + b + {31'd0, ci};
    end

endmodule

// File: rtl/k423_if_pcgen_mf.sv
// k423_if_pcgen_mf: multi-fetch PC generator at the head of the IF stage.
//   clk_i, rst_i         - clock, synchronous active-high reset
//   pcu_clear_pc_i       - load CLEAR_PC and drop any pending redirect
//   pcu_stall_pc_i       - freeze pc; excp/bju redirects are parked in HOLD
//   pc_vld_o / if_rdy_i  - fetch-group handshake
//   excp_*, bju_*, bpu_* - redirect requests (excp > bju > bpu)
//   bpu_br_lane_i        - lane of the predicted-taken branch
//   pc_o, lane_mask_o    - current group start PC and its valid lanes
//   pc_misalign_o        - pc_o[1:0] != 0 while the group is valid
//   next_pc_o            - pc value loaded at the coming clock edge
module k423_if_pcgen_mf
    import k423_if_pkg::*;
#(
    parameter int unsigned          XLEN     = 32,
    parameter int unsigned          FETCH_W  = 2,
    parameter logic [XLEN-1:0]      RST_PC   = 32'h8000_0000,
    parameter logic [XLEN-1:0]      CLEAR_PC = 32'h0000_0000
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        pcu_clear_pc_i,
    input  logic                        pcu_stall_pc_i,
    output logic                        pc_vld_o,
    input  logic                        if_rdy_i,
    input  logic                        excp_br_tkn_i,
    input  logic [XLEN-1:0]             excp_br_pc_i,
    input  logic                        bju_br_tkn_i,
    input  logic [XLEN-1:0]             bju_br_pc_i,
    input  logic                        bpu_br_tkn_i,
    input  logic [XLEN-1:0]             bpu_br_pc_i,
    input  logic [lane_w(FETCH_W)-1:0]  bpu_br_lane_i,
    output logic [XLEN-1:0]             pc_o,
    output logic [FETCH_W-1:0]          lane_mask_o,
    output logic                        pc_misalign_o,
    output logic [XLEN-1:0]             next_pc_o
);

    localparam int unsigned OFF_W  = off_w(FETCH_W);
    localparam int unsigned LW     = lane_w(FETCH_W);
    localparam int unsigned ALIGN  = OFF_W + 2;
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN) - 64'd1);
    localparam logic [31:0]     STRIDE     = 32'(grp_bytes(FETCH_W));

    pcgen_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pend_q, pend_d;
    logic            pc_vld_q;
    logic            hs;
    redir_src_t      src;
    logic [XLEN-1:0] base;
    logic [31:0]     seq_sum;
    logic [XLEN-1:0] seq_next;
    logic [XLEN-1:0] redir_tgt;
    logic [LW-1:0]   off;
    logic [FETCH_W-1:0] mask_raw;

    // Sequential successor is computed from the group-aligned base, so a
    // misaligned pc still advances to the next aligned group.
    assign base = pc_q & ~ALIGN_MASK;

    utils_adder32 u_seq_add (
        .a   (32'(base)),
        .b   (STRIDE),
        .ci  (1'b0),
        .sum (seq_sum)
    );

    assign seq_next = seq_sum[XLEN-1:0];

    generate
        if (OFF_W > 0) begin : g_off
            assign off = pc_q[ALIGN-1:2];
        end else begin : g_no_off
            assign off = '0;
        end
    endgenerate

    k423_if_lane_mask #(
        .FETCH_W (FETCH_W)
    ) u_lane_mask (
        .off      (off),
        .bpu_tkn  (bpu_br_tkn_i),
        .bpu_lane (bpu_br_lane_i),
        .mask     (mask_raw)
    );

    assign hs = pc_vld_q & if_rdy_i;

    // Redirect source for this cycle; stall parks excp/bju instead of applying.
    always_comb begin
        src = REDIR_NONE;
        if (!pcu_clear_pc_i && !pcu_stall_pc_i) begin
            if (excp_br_tkn_i)
                src = REDIR_EXCP;
            else if (bju_br_tkn_i)
                src = REDIR_BJU;
            else if (state_q != ST_HOLD && hs && bpu_br_tkn_i)
                src = REDIR_BPU;
        end
    end

    always_comb begin
        case (src)
            REDIR_EXCP: redir_tgt = excp_br_pc_i;
            REDIR_BJU:  redir_tgt = bju_br_pc_i;
            REDIR_BPU:  redir_tgt = bpu_br_pc_i;
            default:    redir_tgt = seq_next;
        endcase
    end

    always_comb begin
        pc_d    = pc_q;
        pend_d  = pend_q;
        state_d = state_q;
        if (pcu_clear_pc_i) begin
            pc_d    = CLEAR_PC;
            pend_d  = '0;
            state_d = ST_RUN;
        end else if (src == REDIR_EXCP || src == REDIR_BJU) begin
            // A fresh redirect supersedes any parked one.
            pc_d    = redir_tgt;
            state_d = ST_RUN;
        end else if (pcu_stall_pc_i) begin
            if (excp_br_tkn_i) begin
                pend_d  = excp_br_pc_i;
                state_d = ST_HOLD;
            end else if (bju_br_tkn_i) begin
                pend_d  = bju_br_pc_i;
                state_d = ST_HOLD;
            end else if (state_q == ST_IDLE) begin
                state_d = ST_RUN;
            end
        end else if (state_q == ST_HOLD) begin
            pc_d    = pend_q;
            state_d = ST_RUN;
        end else begin
            state_d = ST_RUN;
            if (hs)
                pc_d = redir_tgt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            pc_q     <= RST_PC;
            pend_q   <= '0;
            pc_vld_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            pend_q   <= pend_d;
            pc_vld_q <= (state_d != ST_IDLE);
        end
    end

    assign pc_vld_o      = pc_vld_q;
    assign pc_o          = pc_q;
    assign next_pc_o     = pc_d;
    assign lane_mask_o   = mask_raw & {FETCH_W{pc_vld_q}};
    assign pc_misalign_o = pc_vld_q & (|pc_q[1:0]);

endmodule

// File: tb/tb_k423_if_pcgen_mf.sv
// Directed bench for k423_if_pcgen_mf: a FETCH_W=2 instance covers every
// scenario; a FETCH_W=4 instance on the same inputs covers the 16-byte stride.
module tb_k423_if_pcgen_mf;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        stall;
    logic        rdy;
    logic        excp_tkn;
    logic [31:0] excp_pc;
    logic        bju_tkn;
    logic [31:0] bju_pc;
    logic        bpu_tkn;
    logic [31:0] bpu_pc;
    logic        bpu_lane2;
    logic [1:0]  bpu_lane4;

    logic        vld2, mis2;
    logic [31:0] pc2, npc2;
    logic [1:0]  mask2;
    logic        vld4, mis4;
    logic [31:0] pc4, npc4;
    logic [3:0]  mask4;

    int tests = 0;
    int fails = 0;
    logic seen_100 = 1'b0;

    always #5 clk = ~clk;

    k423_if_pcgen_mf #(
        .XLEN     (32),
        .FETCH_W  (2),
        .RST_PC   (32'h8000_0000),
        .CLEAR_PC (32'h0000_0000)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .pcu_clear_pc_i (clr),
        .pcu_stall_pc_i (stall),
        .pc_vld_o       (vld2),
        .if_rdy_i       (rdy),
        .excp_br_tkn_i  (excp_tkn),
        .excp_br_pc_i   (excp_pc),
        .bju_br_tkn_i   (bju_tkn),
        .bju_br_pc_i    (bju_pc),
        .bpu_br_tkn_i   (bpu_tkn),
        .bpu_br_pc_i    (bpu_pc),
        .bpu_br_lane_i  (bpu_lane2),
        .pc_o           (pc2),
        .lane_mask_o    (mask2),
        .pc_misalign_o  (mis2),
        .next_pc_o      (npc2)
    );

    k423_if_pcgen_mf #(
        .XLEN     (32),
        .FETCH_W  (4),
        .RST_PC   (32'h8000_0000),
        .CLEAR_PC (32'h0000_0000)
    ) dut4 (
        .clk_i          (clk),
        .rst_i          (rst),
        .pcu_clear_pc_i (clr),
        .pcu_stall_pc_i (stall),
        .pc_vld_o       (vld4),
        .if_rdy_i       (rdy),
        .excp_br_tkn_i  (excp_tkn),
        .excp_br_pc_i   (excp_pc),
        .bju_br_tkn_i   (bju_tkn),
        .bju_br_pc_i    (bju_pc),
        .bpu_br_tkn_i   (bpu_tkn),
        .bpu_br_pc_i    (bpu_pc),
        .bpu_br_lane_i  (bpu_lane4),
        .pc_o           (pc4),
        .lane_mask_o    (mask4),
        .pc_misalign_o  (mis4),
        .next_pc_o      (npc4)
    );

    // A parked bju target that was later overridden must never be fetched.
    always @(negedge clk) begin
        if (vld2 && pc2 == 32'h0000_0100)
            seen_100 <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; stall = 1'b0; rdy = 1'b0;
        excp_tkn = 1'b0; excp_pc = '0;
        bju_tkn = 1'b0; bju_pc = '0;
        bpu_tkn = 1'b0; bpu_pc = '0; bpu_lane2 = 1'b0; bpu_lane4 = 2'd0;

        // Reset state
        tick(); tick();
        chk("rst_pc",   pc2, 32'h8000_0000);
        chk("rst_vld",  32'(vld2), 32'd0);
        chk("rst_mask", 32'(mask2), 32'd0);
        chk("rst_mis",  32'(mis2), 32'd0);

        // Sequential run, FETCH_W=2 and FETCH_W=4
        rst = 1'b0; rdy = 1'b1;
        tick();
        chk("run0_vld",  32'(vld2), 32'd1);
        chk("run0_pc",   pc2, 32'h8000_0000);
        chk("run0_mask", 32'(mask2), 32'h3);
        chk("run0_npc",  npc2, 32'h8000_0008);
        chk("w4_run0_pc",   pc4, 32'h8000_0000);
        chk("w4_run0_mask", 32'(mask4), 32'hF);
        chk("w4_run0_npc",  npc4, 32'h8000_0010);
        tick();
        chk("run1_pc",    pc2, 32'h8000_0008);
        chk("w4_run1_pc", pc4, 32'h8000_0010);
        tick();
        chk("run2_pc",    pc2, 32'h8000_0010);
        chk("w4_run2_pc", pc4, 32'h8000_0020);

        // bju redirect without handshake
        rdy = 1'b0; bju_tkn = 1'b1; bju_pc = 32'h8000_0104;
        #1;
        chk("bju_npc", npc2, 32'h8000_0104);
        tick();
        bju_tkn = 1'b0;
        chk("bju_pc",   pc2, 32'h8000_0104);
        chk("bju_mask", 32'(mask2), 32'h2);
        #1;
        chk("bju_hold_npc", npc2, 32'h8000_0104);
        tick();
        chk("bju_stable_pc", pc2, 32'h8000_0104);
        rdy = 1'b1;
        tick();
        chk("bju_seq_pc",   pc2, 32'h8000_0108);
        chk("bju_seq_mask", 32'(mask2), 32'h3);

        // Stall with two parked redirects, latest wins
        stall = 1'b1; bju_tkn = 1'b1; bju_pc = 32'h0000_0100;
        tick();
        chk("hold1_pc", pc2, 32'h8000_0108);
        bju_tkn = 1'b0; excp_tkn = 1'b1; excp_pc = 32'h0000_0200;
        tick();
        excp_tkn = 1'b0;
        chk("hold2_pc", pc2, 32'h8000_0108);
        tick();
        chk("hold3_pc",  pc2, 32'h8000_0108);
        chk("hold3_vld", 32'(vld2), 32'd1);
        stall = 1'b0; rdy = 1'b0;
        #1;
        chk("unhold_npc", npc2, 32'h0000_0200);
        tick();
        chk("unhold_pc", pc2, 32'h0000_0200);

        // Same-cycle excp beats bju while stalled
        stall = 1'b1; excp_tkn = 1'b1; excp_pc = 32'h0000_0900;
        bju_tkn = 1'b1; bju_pc = 32'h0000_0A00;
        tick();
        excp_tkn = 1'b0; bju_tkn = 1'b0; stall = 1'b0;
        tick();
        chk("prio_pc", pc2, 32'h0000_0900);

        // bpu redirect on handshake
        excp_tkn = 1'b1; excp_pc = 32'h8000_0000;
        tick();
        excp_tkn = 1'b0;
        chk("pre_bpu_pc", pc2, 32'h8000_0000);
        bpu_tkn = 1'b1; bpu_lane2 = 1'b0; bpu_pc = 32'h8000_0040; rdy = 1'b1;
        #1;
        chk("bpu_mask", 32'(mask2), 32'h1);
        chk("bpu_npc",  npc2, 32'h8000_0040);
        tick();
        bpu_tkn = 1'b0;
        chk("bpu_pc", pc2, 32'h8000_0040);

        // Clear beats a same-cycle excp and empties the pending register
        rdy = 1'b0; stall = 1'b1; bju_tkn = 1'b1; bju_pc = 32'h0000_0500;
        tick();
        bju_tkn = 1'b0; clr = 1'b1; excp_tkn = 1'b1; excp_pc = 32'h0000_0300;
        tick();
        clr = 1'b0; excp_tkn = 1'b0;
        chk("clr_pc", pc2, 32'h0000_0000);
        stall = 1'b0;
        #1;
        chk("clr_npc", npc2, 32'h0000_0000);
        tick();
        chk("clr_nopend_pc", pc2, 32'h0000_0000);

        // Wrap at top of address space
        excp_tkn = 1'b1; excp_pc = 32'hFFFF_FFF8;
        tick();
        excp_tkn = 1'b0;
        chk("wrap_pre_pc", pc2, 32'hFFFF_FFF8);
        rdy = 1'b1;
        tick();
        chk("wrap_pc", pc2, 32'h0000_0000);

        // Misaligned redirect
        rdy = 1'b0; bju_tkn = 1'b1; bju_pc = 32'h8000_0002;
        tick();
        bju_tkn = 1'b0;
        chk("mis_pc",   pc2, 32'h8000_0002);
        chk("mis_flag", 32'(mis2), 32'd1);
        chk("mis_mask", 32'(mask2), 32'h3);
        rdy = 1'b1;
        #1;
        chk("mis_npc", npc2, 32'h8000_0008);
        tick();
        chk("mis_seq_pc",   pc2, 32'h8000_0008);
        chk("mis_seq_flag", 32'(mis2), 32'd0);

        // Reset while holding discards the pending redirect
        rdy = 1'b0; stall = 1'b1; bju_tkn = 1'b1; bju_pc = 32'h0000_0700;
        tick();
        bju_tkn = 1'b0; stall = 1'b0; rst = 1'b1;
        tick();
        chk("rst2_vld", 32'(vld2), 32'd0);
        chk("rst2_pc",  pc2, 32'h8000_0000);
        rst = 1'b0;
        tick();
        chk("rst2_run_vld", 32'(vld2), 32'd1);
        chk("rst2_run_pc",  pc2, 32'h8000_0000);
        tick();
        chk("rst2_stay_pc", pc2, 32'h8000_0000);

        chk("never_0x100", 32'(seen_100), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/k423_if_pcgen_mf.md
# k423_if_pcgen_mf

- Parametrised multi-fetch PC generator at the head of the IF stage; successor to the single-issue PC generator.
- Produces one aligned fetch group of FETCH_W instructions per handshake, with a per-lane valid mask.
- Arbitrates exception, branch-unit and branch-predictor redirects.
- Holds redirects that arrive during a stall, so none are lost; drives the IF stage through a valid/ready handshake.

## Interface
Parameters:
- XLEN, 32, address/PC width.
- FETCH_W, 2, instructions per fetch group; power of two in {1,2,4}.
- RST_PC, 32'h8000_0000, PC presented after reset.
- CLEAR_PC, 32'h0000_0000, PC loaded by pcu_clear_pc_i.

Ports (one clock; reset is synchronous and active-high):
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- pcu_clear_pc_i  in  1  load CLEAR_PC, drop pending redirect.
- pcu_stall_pc_i  in  1  freeze PC; redirects are captured, not applied.
- pc_vld_o  out  1  fetch group valid.
- if_rdy_i  in  1  IF stage accepts group.
- excp_br_tkn_i / excp_br_pc_i  in  1 / XLEN  exception redirect.
- bju_br_tkn_i / bju_br_pc_i  in  1 / XLEN  branch-unit redirect.
- bpu_br_tkn_i / bpu_br_pc_i  in  1 / XLEN  predicted-taken target for the current group.
- bpu_br_lane_i  in  clog2(FETCH_W) (min 1)  lane holding the predicted branch.
- pc_o  out  XLEN  current group start PC.
- lane_mask_o  out  FETCH_W  valid lanes of the current group.
- pc_misalign_o  out  1  pc_o[1:0] != 0 while pc_vld_o.
- next_pc_o  out  XLEN  PC that the next accepted handshake loads.

## Operation
- States:
  - IDLE: reset state, pc_vld_o=0.
  - RUN: normal fetch.
  - HOLD: stalled with a pending redirect.
- Transitions:
  - IDLE -> RUN on the first clock with rst_i=0.
  - RUN -> HOLD when a redirect arrives while pcu_stall_pc_i=1.
  - HOLD -> RUN on the first cycle with stall=0; the pending target is loaded into pc.
- PC update priority per cycle: rst_i > pcu_clear_pc_i > excp > bju > stall > bpu-on-handshake > sequential-on-handshake.
- Redirects excp/bju with stall=0 load pc next cycle regardless of if_rdy_i; the in-flight group is dead.
- Pending redirect register (HOLD):
  - Written on every excp/bju redirect while stalled.
  - Within a cycle excp beats bju; across cycles the latest cycle wins.
  - Cleared by clear or reset.
- bpu redirect applies only when pc_vld_o & if_rdy_i and no excp/bju/stall.
- Sequential next: base = pc with low log2(FETCH_W)+2 bits zeroed; next = base + FETCH_W*4, wrapping modulo 2^XLEN.
- lane_mask_o[i] = 1 iff off <= i and (no bpu_br_tkn_i, or i <= bpu_br_lane_i), where off = pc[log2(FETCH_W)+1:2].
- Misaligned pc is passed through unchanged; pc_misalign_o flags it. The sequential next still uses the aligned base.
- next_pc_o reflects the pc selection of the current cycle (combinational).

## Timing
- Reset values: pc_o=RST_PC, pc_vld_o=0, lane_mask_o=0, pc_misalign_o=0, state IDLE, pending cleared.
- First cycle after reset release: pc_vld_o=1, pc_o=RST_PC.
- pc_vld_o stays 1 in RUN/HOLD. The group holds stable while if_rdy_i=0, except for excp/bju redirect or clear.
- Redirect-to-fetch latency: 1 cycle; from HOLD, 1 cycle after stall drops.
- Clear and redirect in the same cycle: clear wins.
- Reset mid-HOLD: pending redirect discarded.

## Structure
- Shared package k423_if_pkg holds:
  - redirect-source enum (NONE, EXCP, BJU, BPU);
  - state enum (IDLE, RUN, HOLD);
  - the FETCH_W-derived localparams (offset width, group byte size).
- Sub-module k423_if_lane_mask: combinational lane-mask generator taking offset, bpu taken and lane.
- Sequential increment reuses utils_adder32.

## Test plan
FETCH_W=2, RST_PC=0x8000_0000 unless stated.
- Reset release, if_rdy_i=1 for 3 cycles -> pc_o 0x8000_0000, 0x8000_0008, 0x8000_0010; lane_mask_o=2'b11.
- bju redirect to 0x8000_0104 with stall=0, if_rdy_i=0 -> next cycle pc_o=0x8000_0104, lane_mask_o=2'b10; following handshake gives 0x8000_0108.
- Stall high; bju to 0x100 in cycle 1, excp to 0x200 in cycle 2; stall drops in cycle 4 -> pc_o=0x200 in cycle 5; no 0x100 group is ever presented.
- bpu_br_tkn_i=1, lane 0, target 0x8000_0040 at pc 0x8000_0000 with handshake -> lane_mask_o=2'b01 that cycle, next pc_o=0x8000_0040.
- pcu_clear_pc_i together with excp to 0x300 -> pc_o=0x0 next cycle; pending register empty.
- Edge cases:
  - pc 0xFFFF_FFF8, sequential handshake -> pc_o=0x0000_0000 (wrap).
  - Redirect to 0x8000_0002 -> pc_misalign_o=1.
  - FETCH_W=4 run of the first scenario -> 16-byte strides.
